// File: rtl/iir_sos_cascade.sv
// -----------------------------------------------------------------------------
// iir_sos_cascade
// Cascade of N_SEC direct-form-II biquad sections sharing one multiplier.
// A sample is taken while idle and passes through every section in turn. Each
// section takes five multiply-accumulate cycles: two feedback products, then
// three feed-forward products. One output cycle follows the last section.
//
// Ports
//   clk        rising-edge clock
//   nrst       asynchronous active-low reset
//   in_valid   sample offered on din
//   in_ready   high only while idle; a sample is taken when in_valid is also high
//   din        signed sample, SAMP_WH.SAMP_FR
//   out_valid  one-cycle strobe when dout is updated
//   dout       signed result, SAMP_WH.SAMP_FR, held until the next strobe
//   c_we       coefficient write strobe (applied only while idle)
//   c_addr     coefficient address 5*k + {b0,b1,b2,a1,a2}; out-of-range ignored
//   c_in       signed coefficient, COEFF_WH.COEFF_FR (a1/a2 stored pre-negated)
//   c_err      one-cycle pulse after a write attempted while busy
//   state_clr  clears all delay lines; aborts a computation in progress
//
// Build option
//   IIR_SAT_EN  when defined, the accumulator, w and dout saturate; otherwise
//               they wrap in two's complement.
// -----------------------------------------------------------------------------
module iir_sos_cascade #(
    parameter int SAMP_WH  = 3,
    parameter int SAMP_FR  = 22,
    parameter int COEFF_WH = 2,
    parameter int COEFF_FR = 15,
    parameter int REC_WH   = 7,
    parameter int REC_FR   = 24,
    parameter int N_SEC    = 4
) (
    input  logic                                clk,
    input  logic                                nrst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic signed [SAMP_WH+SAMP_FR-1:0]   din,
    output logic                                out_valid,
    output logic signed [SAMP_WH+SAMP_FR-1:0]   dout,
    input  logic                                c_we,
    input  logic        [$clog2(5*N_SEC)-1:0]   c_addr,
    input  logic signed [COEFF_WH+COEFF_FR-1:0] c_in,
    output logic                                c_err,
    input  logic                                state_clr
);

    localparam int SW    = SAMP_WH + SAMP_FR;
    localparam int CW    = COEFF_WH + COEFF_FR;
    localparam int RW    = REC_WH + REC_FR;
    localparam int NC    = 5 * N_SEC;
    localparam int AW    = $clog2(NC);
    localparam int SEC_W = (N_SEC > 1) ? $clog2(N_SEC) : 1;
    localparam int PW    = RW + CW;
    // Rounded product keeps RW+COEFF_WH bits; one more bit absorbs the add.
    localparam int SUMW  = RW + COEFF_WH + 1;
    localparam int SH    = REC_FR - SAMP_FR;

    localparam logic signed [CW-1:0]   B0_ONE = CW'(1'b1) << COEFF_FR;
    localparam logic signed [PW-1:0]   P_HALF = (PW'(1'b1) << COEFF_FR) >> 1;
    localparam logic signed [RW:0]     D_HALF = ((RW+1)'(1'b1) << SH) >> 1;

`ifdef IIR_SAT_EN
    localparam logic signed [SUMW-1:0] REC_MAX = SUMW'((SUMW'(1'b1) << (RW-1)) - SUMW'(1'b1));
    localparam logic signed [SUMW-1:0] REC_MIN = ~REC_MAX;
    localparam logic signed [RW:0]     SMP_MAX = (RW+1)'(((RW+1)'(1'b1) << (SW-1)) - (RW+1)'(1'b1));
    localparam logic signed [RW:0]     SMP_MIN = ~SMP_MAX;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FB1  = 3'd1,
        S_FB2  = 3'd2,
        S_FF1  = 3'd3,
        S_FF2  = 3'd4,
        S_FF3  = 3'd5,
        S_OUT  = 3'd6
    } state_t;

    // Bring an accumulator sum back to the recursive-state width.
    function automatic logic signed [RW-1:0] fit_rec(input logic signed [SUMW-1:0] v);
`ifdef IIR_SAT_EN
        if (v > REC_MAX) begin
            fit_rec = RW'(REC_MAX);
        end else if (v < REC_MIN) begin
            fit_rec = RW'(REC_MIN);
        end else begin
            fit_rec = RW'(v);
        end
`else
        fit_rec = RW'(v);
`endif
    endfunction

    // Bring a rounded state value back to the sample width.
    function automatic logic signed [SW-1:0] fit_samp(input logic signed [RW:0] v);
`ifdef IIR_SAT_EN
        if (v > SMP_MAX) begin
            fit_samp = SW'(SMP_MAX);
        end else if (v < SMP_MIN) begin
            fit_samp = SW'(SMP_MIN);
        end else begin
            fit_samp = SW'(v);
        end
`else
        fit_samp = SW'(v);
`endif
    endfunction

    state_t                  r_state, w_next;
    logic signed [CW-1:0]    r_coef [NC];
    logic signed [RW-1:0]    r_w1 [N_SEC];
    logic signed [RW-1:0]    r_w2 [N_SEC];
    logic signed [RW-1:0]    r_x;       // input of the current section
    logic signed [RW-1:0]    r_acc;
    logic signed [RW-1:0]    r_w;       // w of the current section
    logic [SEC_W-1:0]        r_sec;
    logic [AW-1:0]           r_cbase;   // 5*r_sec, kept alongside to avoid a multiply
    logic                    r_out_valid;
    logic signed [SW-1:0]    r_dout;
    logic                    r_c_err;

    logic signed [CW-1:0]    w_coef;
    logic signed [RW-1:0]    w_opnd;
    logic signed [RW-1:0]    w_base;
    logic signed [PW-1:0]    w_prod;
    logic signed [PW-1:0]    w_prod_rnd;
    logic signed [SUMW-1:0]  w_prod_x;
    logic signed [SUMW-1:0]  w_sum;
    logic signed [RW-1:0]    w_acc_next;
    logic signed [RW-1:0]    w_din_ext;
    logic signed [RW:0]      w_x_rnd;
    logic                    w_last;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign dout      = r_dout;
    assign c_err     = r_c_err;

    assign w_last     = (r_sec == SEC_W'(N_SEC - 1));
    assign w_din_ext  = RW'(din) <<< SH;
    assign w_prod     = PW'(w_coef) * PW'(w_opnd);
    assign w_prod_rnd = (w_prod + P_HALF) >>> COEFF_FR;
    assign w_prod_x   = SUMW'(w_prod_rnd);
    assign w_sum      = SUMW'(w_base) + w_prod_x;
    assign w_acc_next = fit_rec(w_sum);
    assign w_x_rnd    = ((RW+1)'(r_x) + D_HALF) >>> SH;

    // Select coefficient, multiplier operand and accumulator base per MAC step.
    always_comb begin
        w_coef = '0;
        w_opnd = '0;
        w_base = '0;
        case (r_state)
            S_FB1: begin
                w_coef = r_coef[r_cbase + AW'(3'd3)];
                w_opnd = r_w1[r_sec];
                w_base = r_x;
            end
            S_FB2: begin
                w_coef = r_coef[r_cbase + AW'(3'd4)];
                w_opnd = r_w2[r_sec];
                w_base = r_acc;
            end
            S_FF1: begin
                w_coef = r_coef[r_cbase];
                w_opnd = r_w;
                w_base = '0;
            end
            S_FF2: begin
                w_coef = r_coef[r_cbase + AW'(3'd1)];
                w_opnd = r_w1[r_sec];
                w_base = r_acc;
            end
            S_FF3: begin
                w_coef = r_coef[r_cbase + AW'(3'd2)];
                w_opnd = r_w2[r_sec];
                w_base = r_acc;
            end
            default: begin
                w_coef = '0;
                w_opnd = '0;
                w_base = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; state_clr while busy aborts straight back to idle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next = S_FB1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_FB1: w_next = S_FB2;
            S_FB2: w_next = S_FF1;
            S_FF1: w_next = S_FF2;
            S_FF2: w_next = S_FF3;
            S_FF3: begin
                if (w_last) begin
                    w_next = S_OUT;
                end else begin
                    w_next = S_FB1;
                end
            end
            S_OUT:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (state_clr && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end else begin
            w_next = w_next;
        end
    end

    // Datapath, delay lines, coefficient store and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NC; i++) begin
                r_coef[i] <= ((i % 5) == 0) ? B0_ONE : '0;
            end
            for (int i = 0; i < N_SEC; i++) begin
                r_w1[i] <= '0;
                r_w2[i] <= '0;
            end
            r_x         <= '0;
            r_acc       <= '0;
            r_w         <= '0;
            r_sec       <= '0;
            r_cbase     <= '0;
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_c_err     <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_c_err     <= c_we && (r_state != S_IDLE);
            if (c_we && (r_state == S_IDLE) && (c_addr < AW'(NC))) begin
                r_coef[c_addr] <= c_in;
            end
            if (state_clr && (r_state != S_IDLE)) begin
                for (int i = 0; i < N_SEC; i++) begin
                    r_w1[i] <= '0;
                    r_w2[i] <= '0;
                end
                r_sec   <= '0;
                r_cbase <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (state_clr) begin
                            for (int i = 0; i < N_SEC; i++) begin
                                r_w1[i] <= '0;
                                r_w2[i] <= '0;
                            end
                        end
                        if (in_valid) begin
                            r_x <= w_din_ext;
                        end
                        r_sec   <= '0;
                        r_cbase <= '0;
                    end
                    S_FB1: r_acc <= w_acc_next;
                    S_FB2: r_w   <= w_acc_next;
                    S_FF1: r_acc <= w_acc_next;
                    S_FF2: r_acc <= w_acc_next;
                    S_FF3: begin
                        // Section output becomes the next section's input.
                        r_x         <= w_acc_next;
                        r_w1[r_sec] <= r_w;
                        r_w2[r_sec] <= r_w1[r_sec];
                        if (w_last) begin
                            r_sec   <= '0;
                            r_cbase <= '0;
                        end else begin
                            r_sec   <= r_sec + SEC_W'(1'b1);
                            r_cbase <= r_cbase + AW'(3'd5);
                        end
                    end
                    S_OUT: begin
                        r_out_valid <= 1'b1;
                        r_dout      <= fit_samp(w_x_rnd);
                    end
                    default: r_acc <= r_acc;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iir_sos_cascade.sv
module tb_iir_sos_cascade;

    localparam int SW = 25;
    localparam int RW = 31;
    localparam int CF = 15;
    localparam int N  = 4;
    localparam int NC = 20;
    localparam longint ONE  = 64'sd4194304;   // 1.0 as a sample
    localparam longint C_ONE = 64'sd32768;    // 1.0 as a coefficient

    logic              clk = 1'b0;
    logic              nrst;
    logic              in_valid;
    logic              in_ready;
    logic [SW-1:0]     din;
    logic              out_valid;
    logic [SW-1:0]     dout;
    logic              c_we;
    logic [4:0]        c_addr;
    logic [16:0]       c_in;
    logic              c_err;
    logic              state_clr;

    int n_chk  = 0;
    int n_pass = 0;

    longint m_coef [NC];
    longint m_w1 [N];
    longint m_w2 [N];
    longint m_dout;

    always #5 clk = ~clk;

    iir_sos_cascade #(.N_SEC(N)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .dout      (dout),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_in      (c_in),
        .c_err     (c_err),
        .state_clr (state_clr)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint wrapw(input longint v, input int w);
        longint m;
        m = v & ((64'sd1 <<< w) - 64'sd1);
        if (m >= (64'sd1 <<< (w - 1))) m = m - (64'sd1 <<< w);
        return m;
    endfunction

    function automatic longint fit(input longint v, input int w);
`ifdef IIR_SAT_EN
        longint hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        return wrapw(v, w);
`endif
    endfunction

    function automatic longint mul(input longint c, input longint s);
        return (c * s + (64'sd1 <<< (CF - 1))) >>> CF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) m_coef[i] = ((i % 5) == 0) ? C_ONE : 64'sd0;
        for (int k = 0; k < N; k++) begin m_w1[k] = 0; m_w2[k] = 0; end
        m_dout = 0;
    endtask

    task automatic model_clr();
        for (int k = 0; k < N; k++) begin m_w1[k] = 0; m_w2[k] = 0; end
    endtask

    task automatic model_step(input longint xin, output longint d);
        longint x, w, y;
        x = xin * 4;
        for (int k = 0; k < N; k++) begin
            w = fit(fit(x + mul(m_coef[5*k+3], m_w1[k]), RW) + mul(m_coef[5*k+4], m_w2[k]), RW);
            y = fit(fit(fit(mul(m_coef[5*k], w), RW) + mul(m_coef[5*k+1], m_w1[k]), RW)
                    + mul(m_coef[5*k+2], m_w2[k]), RW);
            m_w2[k] = m_w1[k];
            m_w1[k] = w;
            x = y;
        end
        d = fit((x + 64'sd2) >>> 2, SW);
        m_dout = d;
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic longint sdout();
        return longint'($signed(dout));
    endfunction

    task automatic wait_out(input int start, output int lat);
        lat = start;
        while (out_valid !== 1'b1 && lat < 80) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wr(input int addr, input longint val);
        @(negedge clk);
        c_we = 1'b1; c_addr = addr[4:0]; c_in = val[16:0];
        @(negedge clk);
        c_we = 1'b0;
        chk("c_err_idle_write", c_err, 0);
        if (addr < NC) m_coef[addr] = val;
    endtask

    task automatic set_pass();
        for (int i = 0; i < NC; i++) wr(i, ((i % 5) == 0) ? C_ONE : 64'sd0);
    endtask

    task automatic clr_idle();
        @(negedge clk); state_clr = 1'b1;
        @(negedge clk); state_clr = 1'b0;
        model_clr();
    endtask

    task automatic run(input longint x, input string tag, output longint got);
        longint e;
        int lat;
        @(negedge clk);
        chk({tag, "_ready"}, in_ready, 1);
        in_valid = 1'b1; din = x[SW-1:0];
        model_step(x, e);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(0, lat);
        chk({tag, "_latency"}, lat, 21);
        chk({tag, "_ready_at_out"}, in_ready, 1);
        got = sdout();
        chk({tag, "_dout"}, got, e);
        @(negedge clk);
        chk({tag, "_single_pulse"}, out_valid, 0);
    endtask

    task automatic count_outs(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (out_valid === 1'b1) cnt++;
        end
    endtask

    task automatic impulse3(input string tag);
        longint g;
        for (int i = 0; i < 3; i++) begin
            run((i == 0) ? ONE : 64'sd0, tag, g);
            chk({tag, "_const"}, g, ONE >>> i);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam longint FIR_EXP [4] = '{64'sd1048576, 64'sd2097152, 64'sd3145728, 64'sd3145728};

    initial begin
        longint g, e, xa, xb, x;
        int lat, cnt, saw_neg;

        nrst = 1'b0; in_valid = 1'b0; din = '0; c_we = 1'b0;
        c_addr = '0; c_in = '0; state_clr = 1'b0;
        model_reset();
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dout", sdout(), 0);
        chk("rst_c_err", c_err, 0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;

        // Unity passthrough after reset.
        run(ONE / 2, "pass", g);
        chk("pass_half", g, ONE / 2);

        // FIR section 0, step input.
        wr(0, 64'sd8192); wr(1, 64'sd8192); wr(2, 64'sd8192);
        clr_idle();
        for (int i = 0; i < 4; i++) begin
            run(ONE, "fir_step", g);
            chk("fir_step_const", g, FIR_EXP[i]);
        end

        // First-order recursion in section 0.
        set_pass();
        wr(3, 64'sd16384);
        clr_idle();
        for (int i = 0; i < 4; i++) begin
            run((i == 0) ? ONE : 64'sd0, "iir_imp", g);
            chk("iir_imp_const", g, ONE >>> i);
        end

        // Write while busy (state FF2 of section 0) is dropped and flagged.
        x = ONE / 4;
        @(negedge clk);
        in_valid = 1'b1; din = x[SW-1:0];
        model_step(x, e);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        c_we = 1'b1; c_addr = 5'd0; c_in = 17'd16384;
        @(negedge clk);
        c_we = 1'b0;
        chk("cerr_pulse", c_err, 1);
        @(negedge clk);
        chk("cerr_clear", c_err, 0);
        wait_out(5, lat);
        chk("cerr_latency", lat, 21);
        chk("cerr_dout", sdout(), e);
        run(ONE / 4, "coef_kept", g);

        // Write together with acceptance: new b0 applies to that sample.
        clr_idle();
        @(negedge clk);
        c_we = 1'b1; c_addr = 5'd0; c_in = 17'd16384;
        in_valid = 1'b1; din = x[SW-1:0];
        m_coef[0] = 64'sd16384;
        model_step(x, e);
        @(negedge clk);
        c_we = 1'b0; in_valid = 1'b0;
        chk("cw_accept_no_err", c_err, 0);
        wait_out(0, lat);
        chk("cw_accept_latency", lat, 21);
        chk("cw_accept_dout", sdout(), e);
        chk("cw_accept_const", sdout(), 64'sd524288);
        wr(0, C_ONE);

        // state_clr abort mid-computation.
        clr_idle();
        impulse3("clr_first");
        @(negedge clk);
        in_valid = 1'b1; din = ONE[SW-1:0];
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        state_clr = 1'b1;
        @(negedge clk);
        state_clr = 1'b0;
        chk("abort_idle", in_ready, 1);
        count_outs(30, cnt);
        chk("abort_no_out", cnt, 0);
        chk("abort_dout_held", sdout(), m_dout);
        model_clr();
        impulse3("clr_again");

        // Reset mid-computation.
        @(negedge clk);
        in_valid = 1'b1; din = ONE[SW-1:0];
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        nrst = 1'b0;
        #1;
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_dout", sdout(), 0);
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        count_outs(30, cnt);
        chk("mid_rst_no_out", cnt, 0);
        wr(3, 64'sd16384);
        impulse3("rst_again");

        // Randomised coefficient sets and samples.
        for (int s = 0; s < 3; s++) begin
            for (int a = 0; a < NC; a++) begin
                if ((a % 5) >= 3) wr(a, longint'($urandom_range(0, 19660)) - 64'sd9830);
                else              wr(a, longint'($urandom_range(0, 39320)) - 64'sd19660);
            end
            wr(NC + int'($urandom_range(0, 11)), 64'sd12345);
            clr_idle();
            for (int j = 0; j < 6; j++) begin
                x = longint'($urandom_range(0, 33554431)) - 64'sd16777216;
                run(x, "rand", g);
            end
        end

        // Back-to-back samples with in_valid held high throughout.
        xa = longint'($urandom_range(0, 8388607)) - 64'sd4194304;
        xb = longint'($urandom_range(0, 8388607)) - 64'sd4194304;
        model_step(xa, e);
        @(negedge clk);
        in_valid = 1'b1; din = xa[SW-1:0];
        @(negedge clk);
        wait_out(0, lat);
        chk("b2b_lat_a", lat, 21);
        chk("b2b_dout_a", sdout(), e);
        chk("b2b_ready_a", in_ready, 1);
        din = xb[SW-1:0];
        model_step(xb, e);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(0, lat);
        chk("b2b_lat_b", lat, 21);
        chk("b2b_dout_b", sdout(), e);
        count_outs(30, cnt);
        chk("b2b_no_extra", cnt, 0);

        // Unstable recursion: overflow behaviour.
        set_pass();
        wr(3, 64'sd62259);
        clr_idle();
        saw_neg = 0;
        for (int j = 0; j < 12; j++) begin
            run(64'sd16357786, "ovf", g);
            if (g < 0) saw_neg = 1;
        end
`ifdef IIR_SAT_EN
        chk("ovf_clamp_max", sdout(), 64'sd16777215);
`else
        chk("ovf_wrapped", saw_neg, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
